uart_tx: RTL and testbench



---
 rtl/uart_tx_pkg.sv | 26 ++
 rtl/uart_bit_timer.sv | 39 +++
 rtl/uart_tx.sv | 161 ++++++++++++++++
 tb/tb_uart_tx.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_pkg
//   Shared UART definitions: transmitter FSM state encodings, parity mode
//   constants and small helpers used by the transmit datapath. The receive side
//   uses the same parity constants.
// -----------------------------------------------------------------------------
package uart_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_t;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   // Mask keeping only the low data_bits bits of a byte.
   function automatic logic [7:0] data_mask(input int data_bits);
      return 8'((1 << data_bits) - 1);
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_bit_timer
//   Serial bit-period timer. While enabled it counts 0..CLKS_PER_BIT-1 and
//   wraps; bit_done marks the last clock of every bit period. Disabling it
//   parks the count at 0 so the next frame starts on a fresh period.
//
// Ports
//   clock    in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   enable   in   count while high, hold at 0 while low
//   bit_done out  high on the last clock of each bit period
// -----------------------------------------------------------------------------
module uart_bit_timer #(
   parameter int CLKS_PER_BIT = 104
) (
   input  logic clock,
   input  logic reset_n,
   input  logic enable,
   output logic bit_done
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST_COUNT = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (!enable || (count == LAST_COUNT)) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   assign bit_done = enable && (count == LAST_COUNT);

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//   Byte-serialising UART transmitter. Bytes arrive over a valid/ready
//   handshake into a one-entry holding register, move into a shifter, and are
//   sent as start bit, DATA_BITS data bits LSB first, optional parity bit and
//   STOP_BITS stop bits. A byte waiting in the holding register is launched
//   straight from the last stop-bit clock, so consecutive frames have no gap.
//
// Ports
//   clock     in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   tx_byte   in   byte to send; bits above DATA_BITS-1 are ignored
//   tx_valid  in   tx_byte is valid
//   tx_ready  out  holding register empty, a byte can be accepted
//   serial_tx out  serial line, idles high, driven from a flop
//   busy      out  a frame is on the line
// -----------------------------------------------------------------------------
module uart_tx
   import uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 104,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [7:0] tx_byte,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       serial_tx,
   output logic       busy
);

   localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
   localparam logic       LAST_STOP = 1'(STOP_BITS - 1);
   localparam logic [7:0] MASK      = data_mask(DATA_BITS);

   function automatic logic parity_of(input logic [7:0] data);
      logic x;
      x = ^data;
      return (PARITY == PARITY_ODD) ? ~x : x;
   endfunction

   uart_state_t state_q, state_d;
   logic        hold_valid;
   logic [7:0]  hold_data;
   logic [7:0]  shift_q, shift_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic        stop_cnt_q, stop_cnt_d;
   logic        par_q, par_d;
   logic        line_q, line_d;
   logic        load;
   logic        accept;
   logic        bit_done;

   uart_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_timer (
      .clock   (clock),
      .reset_n (reset_n),
      .enable  (state_q != ST_IDLE),
      .bit_done(bit_done)
   );

   // tx_ready comes straight from the hold flag, so it never depends on tx_valid.
   assign accept = tx_valid && !hold_valid;

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_idx_d  = bit_idx_q;
      stop_cnt_d = stop_cnt_q;
      par_d      = par_q;
      load       = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (hold_valid) load = 1'b1;
         end
         ST_START: begin
            if (bit_done) state_d = ST_DATA;
         end
         ST_DATA: begin
            if (bit_done) begin
               if (bit_idx_q == LAST_BIT) begin
                  state_d    = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                  stop_cnt_d = 1'b0;
               end else begin
                  shift_d   = shift_q >> 1;
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         ST_PARITY: begin
            if (bit_done) begin
               state_d    = ST_STOP;
               stop_cnt_d = 1'b0;
            end
         end
         ST_STOP: begin
            if (bit_done) begin
               if (stop_cnt_q == LAST_STOP) begin
                  // A waiting byte goes straight into its start bit.
                  if (hold_valid) load = 1'b1;
                  else            state_d = ST_IDLE;
               end else begin
                  stop_cnt_d = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (load) begin
         state_d   = ST_START;
         shift_d   = hold_data;
         bit_idx_d = 3'd0;
         par_d     = parity_of(hold_data);
      end

      // The line flop is loaded with the value of the state being entered, so
      // serial_tx changes on the same edge as the state.
      unique case (state_d)
         ST_START:  line_d = 1'b0;
         ST_DATA:   line_d = shift_d[0];
         ST_PARITY: line_d = par_d;
         default:   line_d = 1'b1;
      endcase
   end

   // Control state: asynchronously reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         hold_valid <= 1'b0;
         bit_idx_q  <= 3'd0;
         stop_cnt_q <= 1'b0;
         line_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         bit_idx_q  <= bit_idx_d;
         stop_cnt_q <= stop_cnt_d;
         line_q     <= line_d;
         if (accept)    hold_valid <= 1'b1;
         else if (load) hold_valid <= 1'b0;
      end
   end

   // Data registers: only meaningful while qualified by the control state.
   always_ff @(posedge clock) begin
      if (accept) hold_data <= tx_byte & MASK;
      shift_q <= shift_d;
      par_q   <= par_d;
   end

   assign tx_ready  = !hold_valid;
   assign serial_tx = line_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
//   Four transmitter instances at CLKS_PER_BIT=4: 8N1, 8E1, 8O1, 8N2.
//   Table of frames with hand-computed line patterns (bit i of the pattern is
//   the line level during bit period i, counted from the first start bit),
//   plus hand-written reset and ready-timing sequences.
// -----------------------------------------------------------------------------
module tb_uart_tx;

   localparam int CPB  = 4;
   localparam int MAXK = 200;

   logic       clock = 1'b0;
   logic       reset_n = 1'b1;
   logic [3:0] tx_valid;
   logic [3:0] tx_ready;
   logic [3:0] serial_tx;
   logic [3:0] busy;
   logic [7:0] tx_byte [4];

   always #5 clock = ~clock;

   for (genvar g = 0; g < 4; g++) begin : g_unit
      uart_tx #(
         .CLKS_PER_BIT(CPB),
         .DATA_BITS   (8),
         .PARITY      ((g == 1) ? 1 : ((g == 2) ? 2 : 0)),
         .STOP_BITS   ((g == 3) ? 2 : 1)
      ) dut (
         .clock    (clock),
         .reset_n  (reset_n),
         .tx_byte  (tx_byte[g]),
         .tx_valid (tx_valid[g]),
         .tx_ready (tx_ready[g]),
         .serial_tx(serial_tx[g]),
         .busy     (busy[g])
      );
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   typedef struct {
      string       name;
      int          unit;
      int          nbytes;
      logic [23:0] bytes;
      int          nbits;
      logic [39:0] bits;
   } vec_t;

   function automatic vec_t mk(input string n, input int u, input int nb,
                               input logic [23:0] b, input int nbits, input logic [39:0] bits);
      vec_t v;
      v.name = n; v.unit = u; v.nbytes = nb; v.bytes = b; v.nbits = nbits; v.bits = bits;
      return v;
   endfunction

   logic line_s [MAXK];
   logic busy_s [MAXK];
   logic rdy_s  [MAXK];
   int   acc_cnt;
   int   kend;

   // Sample k=0 is the negedge where the first byte is presented; the byte is
   // taken on the next edge and the start bit shows from sample k=2.
   task automatic run_vec(input vec_t v);
      int   idx;
      logic rdy_prev;
      logic line_ok, busy_ok;
      logic ev, eb;
      int   p;
      idx = 0; rdy_prev = 1'b0; acc_cnt = 0;
      kend = 2 + CPB * v.nbits + 3;
      for (int k = 0; k < kend; k++) begin
         @(negedge clock);
         if (k > 0 && tx_valid[v.unit] && rdy_prev) begin
            acc_cnt++;
            idx++;
         end
         line_s[k] = serial_tx[v.unit];
         busy_s[k] = busy[v.unit];
         rdy_s[k]  = tx_ready[v.unit];
         rdy_prev  = tx_ready[v.unit];
         if (idx < v.nbytes) begin
            tx_valid[v.unit] = 1'b1;
            tx_byte[v.unit]  = v.bytes[8*idx +: 8];
         end else begin
            tx_valid[v.unit] = 1'b0;
         end
      end
      line_ok = 1'b1; busy_ok = 1'b1;
      for (int k = 0; k < kend; k++) begin
         p = k - 2;
         if (p >= 0 && p < CPB * v.nbits) begin
            ev = v.bits[p / CPB]; eb = 1'b1;
         end else begin
            ev = 1'b1; eb = 1'b0;
         end
         if (line_s[k] !== ev) line_ok = 1'b0;
         if (busy_s[k] !== eb) busy_ok = 1'b0;
      end
      check({v.name, "_line"}, 32'(line_ok), 32'd1);
      check({v.name, "_busy"}, 32'(busy_ok), 32'd1);
      check({v.name, "_accepts"}, acc_cnt, v.nbytes);
   endtask

   // tx_ready is low the cycle after each acceptance until the held byte moves
   // into the shifter: right away for the first byte, at the end of the
   // previous frame (40 clocks later) for the others.
   task automatic check_ready(input string name, input int nbytes);
      logic ok;
      logic er;
      ok = 1'b1;
      for (int k = 0; k < kend; k++) begin
         er = 1'b1;
         if (k == 1) er = 1'b0;
         if (nbytes >= 2 && k >= 3 && k <= 41) er = 1'b0;
         if (nbytes >= 3 && k >= 43 && k <= 81) er = 1'b0;
         if (rdy_s[k] !== er) ok = 1'b0;
      end
      check(name, 32'(ok), 32'd1);
   endtask

   vec_t vecs [9];

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tx_valid = '0;
      for (int i = 0; i < 4; i++) tx_byte[i] = 8'h00;

      vecs[0] = mk("n1_55",  0, 1, 24'h000055, 10, 40'h2AA);
      vecs[1] = mk("n1_b2b", 0, 2, 24'h003CA5, 20, {20'h0, 10'h278, 10'h34A});
      vecs[2] = mk("e1_07",  1, 1, 24'h000007, 11, 40'h60E);
      vecs[3] = mk("o1_07",  2, 1, 24'h000007, 11, 40'h40E);
      vecs[4] = mk("n2_ff",  3, 2, 24'h0000FF, 22, {18'h0, 11'h600, 11'h7FE});
      vecs[5] = mk("n1_bp",  0, 3, 24'h030201, 30, {10'h0, 10'h206, 10'h204, 10'h202});
      vecs[6] = mk("e1_00",  1, 1, 24'h000000, 11, 40'h400);
      vecs[7] = mk("o1_00",  2, 1, 24'h000000, 11, 40'h600);
      vecs[8] = mk("n1_ff",  0, 1, 24'h0000FF, 10, 40'h3FE);

      #2 reset_n = 1'b0;
      repeat (3) @(negedge clock);
      check("reset_line",  32'(serial_tx), 32'hF);
      check("reset_ready", 32'(tx_ready),  32'hF);
      check("reset_busy",  32'(busy),      32'h0);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);

      for (int i = 0; i < 9; i++) begin
         run_vec(vecs[i]);
         if (i == 1) check_ready("n1_b2b_ready", 2);
         if (i == 5) check_ready("n1_bp_ready", 3);
         repeat (2) @(negedge clock);
      end

      // Reset in the middle of data bit 3 of 0xF0 (line low there).
      @(negedge clock);
      tx_byte[0]  = 8'hF0;
      tx_valid[0] = 1'b1;
      @(negedge clock);
      tx_valid[0] = 1'b0;
      repeat (18) @(negedge clock);
      check("midrst_pre_line", 32'(serial_tx[0]), 32'd0);
      check("midrst_pre_busy", 32'(busy[0]), 32'd1);
      #1 reset_n = 1'b0;
      #1;
      check("midrst_line",  32'(serial_tx[0]), 32'd1);
      check("midrst_ready", 32'(tx_ready[0]),  32'd1);
      check("midrst_busy",  32'(busy[0]),      32'd0);
      repeat (3) @(negedge clock);
      check("midrst_hold_line", 32'(serial_tx[0]), 32'd1);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);
      check("postrst_idle", 32'({serial_tx[0], busy[0], tx_ready[0]}), 32'b101);
      run_vec(mk("postrst_12", 0, 1, 24'h000012, 10, 40'h224));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
